// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: default widths,
// reset vector and sequencer state encodings.
package pc_sequencer_pkg;

    localparam int          ADDR_W_DEF       = 16;
    localparam int          CNT_W_DEF        = 16;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALTED   = 2'd2
    } state_e;

endpackage

// File: rtl/pc_sequencer_br_stat_counter.sv
// Saturating event counter used for branch statistics; clears only on reset.
module br_stat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues fetch addresses over valid/ready, applies taken
// branch redirects and pulses flush. Optional branch statistics under PC_BR_STATS_EN.
//
// Handshakes: a fetch transfers when o_fetch_valid & i_fetch_ready at a rising edge;
// a branch result is consumed when i_br_valid & o_br_ready at a rising edge. Both
// ready/valid outputs depend on state only.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                CNT_W        = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_br_valid,
    input  logic              i_br_taken,
    input  logic [ADDR_W-1:0] i_br_target,
    output logic              o_br_ready,
    input  logic              i_halt,
    output logic [ADDR_W-1:0] o_fetch_addr,
    output logic              o_fetch_valid,
    input  logic              i_fetch_ready,
    output logic              o_flush,
    output logic [CNT_W-1:0]  o_br_taken_cnt,
    output logic [CNT_W-1:0]  o_br_total_cnt,
    output logic [1:0]        o_state
);

    state_e            r_state;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic              r_flush;

    state_e            w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_flush_nxt;
    logic              w_br_accept;
    logic              w_br_take;
    logic              w_fetch_fire;

    assign o_fetch_valid = (r_state == ST_RUN);
    assign o_br_ready    = (r_state == ST_RUN) || (r_state == ST_HALTED);
    assign o_fetch_addr  = r_fetch_addr;
    assign o_flush       = r_flush;
    assign o_state       = r_state;

    assign w_br_accept  = i_br_valid & o_br_ready;
    assign w_br_take    = w_br_accept & i_br_taken;
    assign w_fetch_fire = o_fetch_valid & i_fetch_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_REDIRECT;
            r_fetch_addr <= RESET_VECTOR;
            r_flush      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_addr <= w_addr_nxt;
            r_flush      <= w_flush_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_fetch_addr;
        w_flush_nxt = 1'b0;
        case (r_state)
            ST_RUN: begin
                // A taken redirect overrides any fetch increment in the same cycle.
                if (w_br_take) begin
                    w_addr_nxt  = i_br_target;
                    w_flush_nxt = 1'b1;
                    w_state_nxt = i_halt ? ST_HALTED : ST_REDIRECT;
                end else begin
                    if (w_fetch_fire) begin
                        w_addr_nxt = r_fetch_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                    if (i_halt) begin
                        w_state_nxt = ST_HALTED;
                    end
                end
            end
            ST_REDIRECT: begin
                w_state_nxt = i_halt ? ST_HALTED : ST_RUN;
            end
            ST_HALTED: begin
                if (w_br_take) begin
                    w_addr_nxt  = i_br_target;
                    w_flush_nxt = 1'b1;
                end else if (!i_halt) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_REDIRECT;
            end
        endcase
    end

`ifdef PC_BR_STATS_EN
    br_stat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_br_take),
        .o_cnt   (o_br_taken_cnt)
    );

    br_stat_counter #(.CNT_W(CNT_W)) u_total_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_br_accept),
        .o_cnt   (o_br_total_cnt)
    );
`else
    assign o_br_taken_cnt = '0;
    assign o_br_total_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch addresses are scoreboarded on every
// handshake, other outputs are checked at fixed points. Honours PC_BR_STATS_EN.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;
`ifdef PC_BR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              br_valid;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              br_ready;
    logic              halt;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic              fetch_ready;
    logic              flush;
    logic [CNT_W-1:0]  br_taken_cnt;
    logic [CNT_W-1:0]  br_total_cnt;
    logic [1:0]        state;

    logic [ADDR_W-1:0] exp_q[$];
    int n_checks;
    int n_errors;
    int exp_taken;
    int exp_total;

    pc_sequencer #(.ADDR_W(ADDR_W), .RESET_VECTOR(16'h0000), .CNT_W(CNT_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_br_valid     (br_valid),
        .i_br_taken     (br_taken),
        .i_br_target    (br_target),
        .o_br_ready     (br_ready),
        .i_halt         (halt),
        .o_fetch_addr   (fetch_addr),
        .o_fetch_valid  (fetch_valid),
        .i_fetch_ready  (fetch_ready),
        .o_flush        (flush),
        .o_br_taken_cnt (br_taken_cnt),
        .o_br_total_cnt (br_total_cnt),
        .o_state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are changed at the falling edge; any fetch transfer about to happen
    // at the next rising edge is compared against the scoreboard first.
    task automatic tick();
        if (fetch_valid && fetch_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_fetch", {16'h0, fetch_addr}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_fetch_addr", {16'h0, fetch_addr}, {16'h0, exp_q.pop_front()});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_taken_cnt"}, {16'h0, br_taken_cnt}, STATS ? exp_taken : 0);
        chk({tag, "_total_cnt"}, {16'h0, br_total_cnt}, STATS ? exp_total : 0);
    endtask

    task automatic branch(input logic taken, input logic [ADDR_W-1:0] target);
        br_valid  = 1'b1;
        br_taken  = taken;
        br_target = target;
    endtask

    task automatic branch_clear();
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
    endtask

    initial begin
        logic [4:0] pattern;
        n_checks = 0;
        n_errors = 0;
        exp_taken = 0;
        exp_total = 0;
        rst_n = 1'b0;
        branch_clear();
        halt = 1'b0;
        fetch_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();

        chk("rst_fetch_addr", {16'h0, fetch_addr}, 32'h0);
        chk("rst_fetch_valid", {31'h0, fetch_valid}, 0);
        chk("rst_br_ready", {31'h0, br_ready}, 0);
        chk("rst_flush", {31'h0, flush}, 0);
        chk("rst_state", {30'h0, state}, ST_REDIRECT);
        chk_counters("rst");

        // Reset release and free-running fetch
        rst_n = 1'b1;
        fetch_ready = 1'b1;
        chk("t1_valid_before", {31'h0, fetch_valid}, 0);
        tick();
        chk("t1_valid_rise", {31'h0, fetch_valid}, 1);
        chk("t1_addr0", {16'h0, fetch_addr}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ADDR_W'(i));
            chk("t1_flush", {31'h0, flush}, 0);
            tick();
        end
        chk("t1_addr4", {16'h0, fetch_addr}, 32'h4);

        // Stall at 5
        exp_q.push_back(16'h4);
        tick();
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_addr", {16'h0, fetch_addr}, 32'h5);
            chk("t2_hold_valid", {31'h0, fetch_valid}, 1);
        end
        fetch_ready = 1'b1;
        exp_q.push_back(16'h5);
        tick();
        chk("t2_advance", {16'h0, fetch_addr}, 32'h6);

        // Taken branch colliding with a fetch handshake at 7
        exp_q.push_back(16'h6);
        tick();
        branch(1'b1, 16'h0040);
        chk("t3_br_ready", {31'h0, br_ready}, 1);
        exp_q.push_back(16'h7);
        tick();
        branch_clear();
        chk("t3_redirect_addr", {16'h0, fetch_addr}, 32'h40);
        chk("t3_flush", {31'h0, flush}, 1);
        chk("t3_bubble_valid", {31'h0, fetch_valid}, 0);
        chk("t3_bubble_br_ready", {31'h0, br_ready}, 0);
        tick();
        chk("t3_resume_valid", {31'h0, fetch_valid}, 1);
        chk("t3_resume_addr", {16'h0, fetch_addr}, 32'h40);
        chk("t3_flush_once", {31'h0, flush}, 0);

        // Move to 9 with a stalled fetch, then a not-taken branch
        fetch_ready = 1'b0;
        branch(1'b1, 16'h0009);
        tick();
        branch_clear();
        chk("t4_redirect_addr", {16'h0, fetch_addr}, 32'h9);
        tick();
        branch(1'b0, 16'h0040);
        fetch_ready = 1'b1;
        exp_q.push_back(16'h9);
        tick();
        branch_clear();
        chk("t4_nt_addr", {16'h0, fetch_addr}, 32'hA);
        chk("t4_nt_flush", {31'h0, flush}, 0);
        chk("t4_nt_valid", {31'h0, fetch_valid}, 1);

        // Halt at FFFF with a stalled request, then wrap
        fetch_ready = 1'b0;
        branch(1'b1, 16'hFFFF);
        tick();
        branch_clear();
        tick();
        chk("t5_at_ffff", {16'h0, fetch_addr}, 32'hFFFF);
        halt = 1'b1;
        tick();
        chk("t5_halted_state", {30'h0, state}, ST_HALTED);
        chk("t5_halted_valid", {31'h0, fetch_valid}, 0);
        chk("t5_halted_addr", {16'h0, fetch_addr}, 32'hFFFF);
        fetch_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t5_halt_valid", {31'h0, fetch_valid}, 0);
            chk("t5_halt_br_ready", {31'h0, br_ready}, 1);
            chk("t5_halt_addr", {16'h0, fetch_addr}, 32'hFFFF);
        end
        halt = 1'b0;
        tick();
        chk("t5_release_valid", {31'h0, fetch_valid}, 1);
        chk("t5_release_addr", {16'h0, fetch_addr}, 32'hFFFF);
        exp_q.push_back(16'hFFFF);
        tick();
        chk("t5_wrap", {16'h0, fetch_addr}, 32'h0);

        // Taken branch accepted while halted
        fetch_ready = 1'b0;
        halt = 1'b1;
        tick();
        branch(1'b1, 16'h0020);
        tick();
        branch_clear();
        chk("th_addr", {16'h0, fetch_addr}, 32'h20);
        chk("th_flush", {31'h0, flush}, 1);
        chk("th_state", {30'h0, state}, ST_HALTED);
        chk("th_valid", {31'h0, fetch_valid}, 0);
        tick();
        chk("th_flush_once", {31'h0, flush}, 0);
        halt = 1'b0;
        tick();
        chk("th_run_state", {30'h0, state}, ST_RUN);
        chk("th_run_addr", {16'h0, fetch_addr}, 32'h20);

        // Reset mid-operation with a pending branch and stalled fetch
        branch(1'b1, 16'h0033);
        rst_n = 1'b0;
        tick();
        branch_clear();
        chk("mrst_addr", {16'h0, fetch_addr}, 32'h0);
        chk("mrst_valid", {31'h0, fetch_valid}, 0);
        chk("mrst_br_ready", {31'h0, br_ready}, 0);
        chk("mrst_flush", {31'h0, flush}, 0);
        chk_counters("mrst");
        rst_n = 1'b1;
        tick();

        // Branch statistics: 3 taken + 2 not-taken
        pattern = 5'b10101;
        for (int k = 0; k < 5; k++) begin
            branch(pattern[k], ADDR_W'(16'h0100 + k));
            chk("t6_br_ready", {31'h0, br_ready}, 1);
            tick();
            branch_clear();
            exp_total++;
            if (pattern[k]) begin
                exp_taken++;
                chk("t6_target", {16'h0, fetch_addr}, 32'h100 + k);
                tick();
            end
        end
        chk_counters("t6");
        rst_n = 1'b0;
        tick();
        exp_taken = 0;
        exp_total = 0;
        chk_counters("t6_rst");

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
